fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//   Sequences the 8-bit program_counter to fetch 32-bit instructions from byte-wide instruction memory.
//   Drives update_lsbs/update_msbs/jump/branch, assembles 4 bytes into instr, offers it to decode via valid/ready.
//   Sits between program_counter + instruction memory and the decode stage; sole owner of the PC controls.
// PARAMETERS
//   BIG_ENDIAN  1  1: byte at addr[1:0]=00 -> instr[31:24]; 0: byte 00 -> instr[7:0]
//   TARGET_W    6  width of jump target / branch offset; must equal PC word-index width (6)
// PORTS
//   clk               in   1   system clock, rising edge
//   rst_n             in   1   asynchronous active-low reset; shared with program_counter
//   enable            in   1   fetch enable; low pauses fetching
//   mem_data          in   8   instruction memory read data; combinational from current mem_addr
//   update_lsbs       out  1   to PC: advance byte index mem_addr[1:0]
//   update_msbs       out  1   to PC: advance word index mem_addr[7:2]
//   jump              out  1   to PC: load word index with jump_destination
//   jump_destination  out  6   to PC: absolute word target
//   branch            out  1   to PC: add sign-extended branch_offset to word index
//   branch_offset     out  6   to PC: signed word offset (two's complement)
//   instr             out  32  assembled instruction
//   instr_valid       out  1   instr complete and stable
//   instr_ready       in   1   decode accepts instr this cycle
//   jump_req          in   1   with handshake: redirect to jump_target
//   jump_target       in   6   absolute word target
//   branch_req        in   1   with handshake: redirect by branch_off
//   branch_off        in   6   signed word offset, relative to the word just fetched
// BEHAVIOUR
//   - Reset: state IDLE, byte_cnt=0, instr=0, all other outputs 0 (immediate, async). PC resets on same rst_n -> addr 00.
//   - All outputs registered (Moore); no combinational input->output paths.
//   - States: IDLE, FETCH, VALID, ADVANCE.
//   - IDLE: enable=1 -> FETCH next cycle.
//   - FETCH: per cycle with enable=1: capture mem_data into slot byte_cnt, update_lsbs=1, byte_cnt+=1 (2-bit wrap).
//     Capture of byte 3 -> VALID; PC lsbs have wrapped to 00, so msbs still point at the fetched word.
//     enable=0 in FETCH: update_lsbs=0, no capture, byte_cnt held; resumes same slot when enable returns.
//   - VALID: instr_valid=1, instr held stable. Handshake = instr_valid & instr_ready.
//     On handshake: latch redirect type (jump_req wins over branch_req), target/offset; -> ADVANCE.
//     jump_req/branch_req ignored outside handshake cycle. enable ignored in VALID.
//   - ADVANCE (exactly 1 cycle): instr_valid=0; exactly one of jump / branch / update_msbs =1 for this cycle,
//     with jump_destination / branch_offset driven from latched values; then enable ? FETCH : IDLE.
//   - jump_destination/branch_offset hold last latched value otherwise; control pulses never overlap.
//   - Throughput: 4 FETCH + >=1 VALID + 1 ADVANCE = 6 cycles per instruction minimum.
//   - Branch arithmetic done by PC: word = word + sext(branch_off), mod 64 (wraps both directions).
//   - Byte-index wrap 11->00 is the PC's; byte_cnt must track it (both reset to 0, both advance only on update_lsbs).
//   - Reset mid-operation: partial instr discarded, return to IDLE, instr cleared.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds output retired_cnt [15:0]; reset 0; +1 per handshake; wraps FFFF->0000.
//   Not defined: port and counter absent; behaviour otherwise identical.
// TESTING
//   1 Mem[00..03]=12 34 56 78, enable=1 -> update_lsbs 4 cycles, addr 00,01,02,03; instr=0x12345678, instr_valid=1.
//   2 Handshake, no req -> update_msbs pulse 1 cycle; next fetch addr 04..07; BIG_ENDIAN=0 gives 0x78563412 for test 1.
//   3 Handshake jump_req=1, jump_target=0x0F (branch_req=1 too) -> jump pulse only, dest 0x0F; next fetch 3C..3F.
//   4 At word 0x0A, branch_off=0x3F -> branch pulse, next fetch at 0x24; from 0x24 off 0x04 -> fetch at 0x34.
//   5 instr_ready=0 for 3 cycles in VALID -> instr_valid, instr stable, no PC pulses; accepted on 4th.
//   6 enable=0 after 2 bytes -> addr held at 02, no update_lsbs; resume -> correct word. rst_n=0 mid-fetch -> all 0, IDLE.

Source files
------------

// File: rtl/fetch_controller_if.sv
// Decode-side handshake bundle for fetch_controller: instruction, valid/ready, and redirect requests.
// master = fetch side (drives instr/instr_valid), slave = decode side (drives ready and redirect requests).
interface fetch_controller_if #(
   parameter int TARGET_W = 6
);
   logic [31:0]         instr;
   logic                instr_valid;
   logic                instr_ready;
   logic                jump_req;
   logic [TARGET_W-1:0] jump_target;
   logic                branch_req;
   logic [TARGET_W-1:0] branch_off;

   modport master (
      output instr,
      output instr_valid,
      input  instr_ready,
      input  jump_req,
      input  jump_target,
      input  branch_req,
      input  branch_off
   );

   modport slave (
      input  instr,
      input  instr_valid,
      output instr_ready,
      output jump_req,
      output jump_target,
      output branch_req,
      output branch_off
   );
endinterface

// File: rtl/fetch_controller.sv
// Fetch controller: steps the program counter byte by byte, assembles a 32-bit instr, hands it to decode.
// Ports: clk, rst_n (async low), enable, mem_data in; PC controls update_lsbs/update_msbs/jump/
// jump_destination/branch/branch_offset out; dec = decode handshake (fetch_controller_if.master).
// Optional: define FETCH_PERF_CNT_EN to add retired_cnt[15:0], a wrapping count of accepted instructions.
module fetch_controller #(
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int TARGET_W   = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [7:0]          mem_data,
   output logic                update_lsbs,
   output logic                update_msbs,
   output logic                jump,
   output logic [TARGET_W-1:0] jump_destination,
   output logic                branch,
   output logic [TARGET_W-1:0] branch_offset,
   fetch_controller_if.master  dec
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]         retired_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      VALID,
      ADVANCE
   } state_t;

   state_t     state;
   logic [1:0] byte_cnt;
   logic [1:0] slot;
   logic       hs;

   // Byte order: big-endian puts byte 0 in the top lane.
   always_comb begin
      slot = byte_cnt;
      if (BIG_ENDIAN)
         slot = ~byte_cnt;
   end

   assign hs = dec.instr_valid & dec.instr_ready;

   // byte_cnt advances only while update_lsbs is high, exactly as the
   // PC byte index does, so the two can never drift apart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         byte_cnt         <= 2'd0;
         dec.instr        <= 32'd0;
         dec.instr_valid  <= 1'b0;
         update_lsbs      <= 1'b0;
         update_msbs      <= 1'b0;
         jump             <= 1'b0;
         branch           <= 1'b0;
         jump_destination <= '0;
         branch_offset    <= '0;
`ifdef FETCH_PERF_CNT_EN
         retired_cnt      <= 16'd0;
`endif
      end else begin
         update_msbs <= 1'b0;
         jump        <= 1'b0;
         branch      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (enable) begin
                  state       <= FETCH;
                  update_lsbs <= 1'b1;
               end
            end
            FETCH: begin
               if (update_lsbs) begin
                  dec.instr[{slot, 3'b000} +: 8] <= mem_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state           <= VALID;
                     update_lsbs     <= 1'b0;
                     dec.instr_valid <= 1'b1;
                  end else begin
                     update_lsbs <= enable;
                  end
               end else begin
                  update_lsbs <= enable;
               end
            end
            VALID: begin
               if (hs) begin
                  state           <= ADVANCE;
                  dec.instr_valid <= 1'b0;
                  if (dec.jump_req) begin
                     jump             <= 1'b1;
                     jump_destination <= dec.jump_target;
                  end else if (dec.branch_req) begin
                     branch        <= 1'b1;
                     branch_offset <= dec.branch_off;
                  end else begin
                     update_msbs <= 1'b1;
                  end
`ifdef FETCH_PERF_CNT_EN
                  retired_cnt <= retired_cnt + 16'd1;
`endif
               end
            end
            ADVANCE: begin
               update_lsbs <= enable;
               if (enable)
                  state <= FETCH;
               else
                  state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: PC + byte memory model, table of fetch/redirect vectors,
// plus hand sequences for enable pause, little-endian assembly and reset mid-fetch.
module tb_fetch_controller;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [256];

   // big-endian DUT and its PC model
   fetch_controller_if be_if ();
   logic       lsbs, msbs, jmp, br;
   logic [5:0] jdest, boff;
   logic [5:0] pc_word;
   logic [1:0] pc_byte;
   logic [7:0] mem_data;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] retired;
   logic [15:0] le_retired;
`endif

   assign mem_data = mem[{pc_word, pc_byte}];

   fetch_controller #(.BIG_ENDIAN(1'b1), .TARGET_W(6)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .mem_data         (mem_data),
      .update_lsbs      (lsbs),
      .update_msbs      (msbs),
      .jump             (jmp),
      .jump_destination (jdest),
      .branch           (br),
      .branch_offset    (boff),
      .dec              (be_if.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .retired_cnt      (retired)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_word <= 6'd0;
         pc_byte <= 2'd0;
      end else begin
         if (jmp)
            pc_word <= jdest;
         else if (br)
            pc_word <= pc_word + boff;
         else if (msbs)
            pc_word <= pc_word + 6'd1;
         if (lsbs)
            pc_byte <= pc_byte + 2'd1;
      end
   end

   // little-endian DUT, only ever fetches word 0
   fetch_controller_if le_if ();
   logic       le_lsbs, le_msbs, le_jmp, le_br;
   logic [5:0] le_jdest, le_boff;
   logic [1:0] le_byte;
   logic [7:0] le_mem_data;

   assign le_mem_data = mem[{6'd0, le_byte}];

   fetch_controller #(.BIG_ENDIAN(1'b0), .TARGET_W(6)) dut_le (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .mem_data         (le_mem_data),
      .update_lsbs      (le_lsbs),
      .update_msbs      (le_msbs),
      .jump             (le_jmp),
      .jump_destination (le_jdest),
      .branch           (le_br),
      .branch_offset    (le_boff),
      .dec              (le_if.master)
`ifdef FETCH_PERF_CNT_EN
      ,
      .retired_cnt      (le_retired)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         le_byte <= 2'd0;
      else if (le_lsbs)
         le_byte <= le_byte + 2'd1;
   end

   logic overlap = 1'b0;
   always @(negedge clk)
      if (rst_n && (32'(lsbs) + 32'(msbs) + 32'(jmp) + 32'(br)) > 1)
         overlap <= 1'b1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Samples at negedges until instr_valid; checks fetch addresses and instr.
   task automatic run_fetch(input string name, input logic [5:0] w,
                            input int first, input logic [31:0] exp);
      int   n = 0;
      logic ok = 1'b1;
      logic [7:0] ea;
      for (int c = 0; c < 40; c++) begin
         if (lsbs) begin
            ea = {w, 2'b00} + 8'(first + n);
            if ({pc_word, pc_byte} !== ea)
               ok = 1'b0;
            n++;
         end
         if (be_if.instr_valid)
            break;
         @(negedge clk);
      end
      chk({name, "_valid"}, 32'(be_if.instr_valid), 32'd1);
      chk({name, "_nbytes"}, 32'(n), 32'(4 - first));
      chk({name, "_addrs"}, 32'(ok), 32'd1);
      chk({name, "_instr"}, be_if.instr, exp);
   endtask

   // kind: 0 = update_msbs, 1 = jump, 2 = branch
   task automatic handshake(input string name, input int delay,
                            input logic jr, input logic [5:0] jt,
                            input logic brq, input logic [5:0] bo,
                            input int kind, input logic [5:0] nxt);
      logic [31:0] held;
      logic        ok = 1'b1;
      logic [3:0]  exp_p;
      held = be_if.instr;
      for (int d = 0; d < delay; d++) begin
         be_if.jump_req   = 1'b1;
         be_if.branch_req = 1'b1;
         @(negedge clk);
         if (!be_if.instr_valid || be_if.instr !== held ||
             {jmp, br, msbs, lsbs} !== 4'b0000)
            ok = 1'b0;
      end
      chk({name, "_hold"}, 32'(ok), 32'd1);
      be_if.instr_ready = 1'b1;
      be_if.jump_req    = jr;
      be_if.jump_target = jt;
      be_if.branch_req  = brq;
      be_if.branch_off  = bo;
      @(negedge clk);
      be_if.instr_ready = 1'b0;
      be_if.jump_req    = 1'b0;
      be_if.branch_req  = 1'b0;
      be_if.jump_target = 6'h2A;
      be_if.branch_off  = 6'h15;
      exp_p = (kind == 1) ? 4'b1000 : (kind == 2) ? 4'b0100 : 4'b0010;
      chk({name, "_pulse"}, 32'({jmp, br, msbs, lsbs}), 32'(exp_p));
      chk({name, "_novalid"}, 32'(be_if.instr_valid), 32'd0);
      if (kind == 1)
         chk({name, "_dest"}, 32'(jdest), 32'(jt));
      if (kind == 2)
         chk({name, "_off"}, 32'(boff), 32'(bo));
      @(negedge clk);
      chk({name, "_next"}, 32'({pc_word, pc_byte}), 32'({nxt, 2'b00}));
   endtask

   typedef struct {
      int          delay;
      logic        jr;
      logic [5:0]  jt;
      logic        brq;
      logic [5:0]  bo;
      logic [5:0]  word;
      logic [31:0] exp_instr;
      int          kind;
      logic [5:0]  nxt;
   } vec_t;

   vec_t vecs [9];

   initial begin
      vecs[0] = '{0, 1'b0, 6'h00, 1'b0, 6'h00, 6'h00, 32'h12345678, 0, 6'h01};
      vecs[1] = '{1, 1'b1, 6'h0F, 1'b1, 6'h01, 6'h01, 32'h04050607, 1, 6'h0F};
      vecs[2] = '{0, 1'b1, 6'h0A, 1'b0, 6'h00, 6'h0F, 32'h3C3D3E3F, 1, 6'h0A};
      vecs[3] = '{0, 1'b0, 6'h00, 1'b1, 6'h3F, 6'h0A, 32'h28292A2B, 2, 6'h09};
      vecs[4] = '{2, 1'b0, 6'h00, 1'b1, 6'h04, 6'h09, 32'h24252627, 2, 6'h0D};
      vecs[5] = '{3, 1'b1, 6'h01, 1'b0, 6'h00, 6'h0D, 32'h34353637, 1, 6'h01};
      vecs[6] = '{0, 1'b0, 6'h00, 1'b1, 6'h3C, 6'h01, 32'h04050607, 2, 6'h3D};
      vecs[7] = '{0, 1'b0, 6'h00, 1'b1, 6'h05, 6'h3D, 32'hF4F5F6F7, 2, 6'h02};
      vecs[8] = '{0, 1'b0, 6'h00, 1'b0, 6'h00, 6'h02, 32'h08090A0B, 0, 6'h03};

      for (int i = 0; i < 256; i++)
         mem[i] = 8'(i);
      mem[0] = 8'h12;
      mem[1] = 8'h34;
      mem[2] = 8'h56;
      mem[3] = 8'h78;

      rst_n             = 1'b0;
      enable            = 1'b0;
      be_if.instr_ready = 1'b0;
      be_if.jump_req    = 1'b0;
      be_if.jump_target = 6'h00;
      be_if.branch_req  = 1'b0;
      be_if.branch_off  = 6'h00;
      le_if.instr_ready = 1'b0;
      le_if.jump_req    = 1'b0;
      le_if.jump_target = 6'h00;
      le_if.branch_req  = 1'b0;
      le_if.branch_off  = 6'h00;

      @(negedge clk);
      chk("rst_outs", 32'({lsbs, msbs, jmp, br, be_if.instr_valid}), 32'd0);
      chk("rst_instr", be_if.instr, 32'd0);
      chk("rst_tgts", 32'({jdest, boff}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("idle_no_en", 32'({lsbs, be_if.instr_valid}), 32'd0);
      enable = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_fetch($sformatf("v%0d", i), vecs[i].word, 0, vecs[i].exp_instr);
         if (i == 0) begin
            chk("le_valid", 32'(le_if.instr_valid), 32'd1);
            chk("le_instr", le_if.instr, 32'h78563412);
         end
         handshake($sformatf("v%0d", i), vecs[i].delay, vecs[i].jr,
                   vecs[i].jt, vecs[i].brq, vecs[i].bo, vecs[i].kind,
                   vecs[i].nxt);
      end

      // enable pause after two bytes of word 3
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      begin
         logic ok = 1'b1;
         for (int c = 0; c < 3; c++) begin
            if (lsbs || pc_byte !== 2'd2 || be_if.instr_valid)
               ok = 1'b0;
            @(negedge clk);
         end
         chk("pause_hold", 32'(ok), 32'd1);
      end
      enable = 1'b1;
      @(negedge clk);
      run_fetch("resume", 6'h03, 2, 32'h0C0D0E0F);
      handshake("resume", 0, 1'b0, 6'h00, 1'b0, 6'h00, 0, 6'h04);

`ifdef FETCH_PERF_CNT_EN
      chk("retired", 32'(retired), 32'd10);
`endif

      // reset in the middle of fetching word 4
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", 32'({lsbs, msbs, jmp, br, be_if.instr_valid}), 32'd0);
      chk("midrst_instr", be_if.instr, 32'd0);
      chk("midrst_pc", 32'({pc_word, pc_byte}), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("midrst_retired", 32'(retired), 32'd0);
`endif
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_idle", 32'({lsbs, be_if.instr_valid}), 32'd0);
      enable = 1'b1;
      run_fetch("after_rst", 6'h00, 0, 32'h12345678);

      chk("no_overlap", 32'(overlap), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
